// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock with the carry kept in a register.
// Latency N+1 cycles from the start edge to done; start is ignored while busy.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = (CHUNK > 0) ? WIDTH / CHUNK : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cmsb_q, cmsb_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK:0]   chunk_res;
    logic             last_chunk;

    // Operands shift right each RUN cycle so the active chunk is always at the bottom,
    // and results shift in from the top so chunk k lands at bits [k*CHUNK +: CHUNK].
    always_comb begin
        chunk_a    = opa_q[CHUNK-1:0];
        chunk_b    = opb_q[CHUNK-1:0];
        chunk_res  = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
        last_chunk = (cnt_q == CW'(N - 1));

        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                opa_d   = opa_q >> CHUNK;
                opb_d   = opb_q >> CHUNK;
                sum_d   = WIDTH'({chunk_res[CHUNK-1:0], sum_q} >> CHUNK);
                carry_d = chunk_res[CHUNK];
                cnt_d   = cnt_q + CW'(1);
                if (last_chunk) begin
                    // sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly
                    cmsb_d  = chunk_res[CHUNK-1] ^ chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1];
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                cout_d  = carry_q;
                ovf_d   = cmsb_q ^ carry_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed and randomised checks of seq_chunk_adder at several WIDTH/CHUNK settings.
module tb_seq_chunk_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, cin, sub;
    logic [15:0] a, b;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;

    logic        s_start, s_cin, s_sub;
    logic [31:0] s_a, s_b;
    logic        s1_busy, s1_done, s1_cout, s1_ovf;
    logic [7:0]  s1_sum;
    logic        s8_busy, s8_done, s8_cout, s8_ovf;
    logic [7:0]  s8_sum;
    logic        s32_busy, s32_done, s32_cout, s32_ovf;
    logic [31:0] s32_sum;

    int checks = 0;
    int errors = 0;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut_8x1 (
        .clk(clk), .rst(rst), .start(s_start), .a(s_a[7:0]), .b(s_b[7:0]), .cin(s_cin), .sub(s_sub),
        .busy(s1_busy), .done(s1_done), .sum(s1_sum), .cout(s1_cout), .ovf(s1_ovf)
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut_8x8 (
        .clk(clk), .rst(rst), .start(s_start), .a(s_a[7:0]), .b(s_b[7:0]), .cin(s_cin), .sub(s_sub),
        .busy(s8_busy), .done(s8_done), .sum(s8_sum), .cout(s8_cout), .ovf(s8_ovf)
    );

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut_32x8 (
        .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub),
        .busy(s32_busy), .done(s32_done), .sum(s32_sum), .cout(s32_cout), .ovf(s32_ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain wide arithmetic and the sign rule for overflow.
    function automatic logic [33:0] ref_model(input int w, input logic [31:0] x, input logic [31:0] y,
                                              input logic ci, input logic sb);
        logic [32:0] mask, aa, bb, tot, s;
        logic        co, ov;
        mask = (33'd1 << w) - 33'd1;
        aa   = {1'b0, x} & mask;
        bb   = (sb ? ~{1'b0, y} : {1'b0, y}) & mask;
        tot  = aa + bb + {32'd0, ci ^ sb};
        s    = tot & mask;
        co   = tot[w];
        ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {ov, co, s[31:0]};
    endfunction

    // One op on the 16/4 instance: checks latency, busy length, pulse width and result.
    task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tcin, input logic tsub,
                         input logic [15:0] es, input logic ec, input logic eo);
        int lat, bcnt;
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF;
        lat = -1; bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            if (busy) bcnt++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 64'(lat), 64'd5);
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'd5);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_sum"}, 64'(sum), 64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
        @(negedge clk);
        check({tag, "_done_width"}, 64'(done), 64'd0);
    endtask

    initial begin
        int lat, bcnt, ndone, l1, l8, l32;
        logic [33:0] e1, e8, e32;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        s_start = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
        #12;
        check("reset_outputs", {59'd0, busy, done, cout, ovf, 1'b0} | 64'(sum), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("add_basic",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op("add_carry",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("add_cin",    16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
        do_op("sub_neg",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        do_op("sub_borrow", 16'h0010, 16'h0010, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);

        // start held high through an op, with operands changed mid-run
        @(negedge clk);
        a = 16'h0102; b = 16'h0304; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'h7777; b = 16'h1111; cin = 1'b1; sub = 1'b1;
        lat = -1; bcnt = 0; ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                lat = i;
                start = 1'b0;
                break;
            end
            if (busy) bcnt++;
            @(negedge clk);
        end
        check("hold_latency", 64'(lat), 64'd5);
        check("hold_busy_cycles", 64'(bcnt), 64'd5);
        check("hold_sum", 64'(sum), 64'h0406);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("hold_single_done", 64'(ndone), 64'd0);
        check("hold_idle_after", 64'(busy), 64'd0);
        do_op("after_hold", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        // asynchronous reset two cycles into an op
        @(negedge clk);
        a = 16'h1111; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_sum", 64'(sum), 64'd0);
        check("reset_cout_ovf", {62'd0, cout, ovf}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("reset_no_done", 64'(ndone), 64'd0);
        do_op("post_reset", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        // randomised sweep over the other parameter sets
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            s_a = $urandom; s_b = $urandom;
            s_cin = 1'($urandom_range(0, 1)); s_sub = 1'($urandom_range(0, 1));
            if (n == 0) begin s_a = 32'h0000_007F; s_b = 32'h0000_0001; s_cin = 1'b0; s_sub = 1'b0; end
            if (n == 1) begin s_a = 32'h8000_0000; s_b = 32'h0000_0001; s_cin = 1'b0; s_sub = 1'b1; end
            e1  = ref_model(8,  s_a, s_b, s_cin, s_sub);
            e8  = ref_model(8,  s_a, s_b, s_cin, s_sub);
            e32 = ref_model(32, s_a, s_b, s_cin, s_sub);
            s_start = 1'b1;
            @(negedge clk);
            s_start = 1'b0;
            s_a = ~s_a; s_b = ~s_b;
            l1 = -1; l8 = -1; l32 = -1;
            for (int i = 0; i < 12; i++) begin
                if (s1_done) begin
                    if (l1 < 0) l1 = i;
                    check("sweep_8x1_result", {30'd0, s1_ovf, s1_cout, 32'(s1_sum)}, 64'(e1));
                end
                if (s8_done) begin
                    if (l8 < 0) l8 = i;
                    check("sweep_8x8_result", {30'd0, s8_ovf, s8_cout, 32'(s8_sum)}, 64'(e8));
                end
                if (s32_done) begin
                    if (l32 < 0) l32 = i;
                    check("sweep_32x8_result", {30'd0, s32_ovf, s32_cout, s32_sum}, 64'(e32));
                end
                @(negedge clk);
            end
            check("sweep_8x1_latency", 64'(l1), 64'd9);
            check("sweep_8x8_latency", 64'(l8), 64'd2);
            check("sweep_32x8_latency", 64'(l32), 64'd5);
        end
        check("sweep_idle", {61'd0, s1_busy, s8_busy, s32_busy}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
